// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: MEM_DEPTH x 32-bit storage with programmable wait states,
// little-endian byte/halfword/word lanes and a two-cycle ERROR response.
//
//   state | meaning
//   IDLE  | no data phase in progress, ready with OKAY
//   WAIT  | OKAY transfer stalled while the wait counter runs down
//   LAST  | final OKAY data-phase cycle; a pending write commits at its end
//   ERR1  | first ERROR cycle, Hreadyout low
//   ERR2  | second ERROR cycle, Hreadyout high
module ahb_sram_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic                  Hsel,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [1:0]            Htrans,
    input  logic                  Hwrite,
    input  logic [2:0]            Hsize,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic                  Hready,
    output logic [DATA_WIDTH-1:0] Hrdata,
    output logic [1:0]            Hresp,
    output logic                  Hreadyout
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_LAST = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-3:0] DEPTH_LIM = (ADDR_WIDTH-2)'(MEM_DEPTH);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [2:0]            state, state_nxt;
    logic [3:0]            wait_cnt, wait_cnt_nxt;
    logic                  xfer_write;
    logic [IDX_W-1:0]      xfer_idx;
    logic [3:0]            xfer_mask;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-3:0] word_idx;
    logic [IDX_W-1:0]      acc_idx;
    logic [3:0]            acc_mask;
    logic                  can_accept, accept, acc_err, commit;
    logic [DATA_WIDTH-1:0] fwd_word;
    logic                  unused_htrans;

    assign unused_htrans = Htrans[0];
    assign word_idx      = Haddr[ADDR_WIDTH-1:2];
    assign acc_idx       = word_idx[IDX_W-1:0];

    // Address inputs are only looked at while our own Hreadyout is high.
    assign can_accept = (state == ST_IDLE) || (state == ST_LAST) || (state == ST_ERR2);
    assign accept     = can_accept && Hsel && Hready && Htrans[1];
    assign commit     = (state == ST_LAST) && xfer_write;

    always_comb begin
        acc_err = 1'b0;
        if (Hsize > 3'b010)                          acc_err = 1'b1;
        if ((Hsize == 3'b001) && Haddr[0])           acc_err = 1'b1;
        if ((Hsize == 3'b010) && (Haddr[1:0] != 2'b00)) acc_err = 1'b1;
        if (word_idx >= DEPTH_LIM)                   acc_err = 1'b1;
    end

    always_comb begin
        case (Hsize)
            3'b000:  acc_mask = 4'b0001 << Haddr[1:0];
            3'b001:  acc_mask = Haddr[1] ? 4'b1100 : 4'b0011;
            default: acc_mask = 4'b1111;
        endcase
    end

    // A read accepted on the edge that commits a write to the same word sees the new lanes.
    always_comb begin
        fwd_word = mem[acc_idx];
        if (commit && (xfer_idx == acc_idx)) begin
            for (int i = 0; i < 4; i++) begin
                if (xfer_mask[i]) fwd_word[8*i +: 8] = Hwdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = ST_LAST;
                else                  wait_cnt_nxt = wait_cnt - 4'd1;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
        if (accept) begin
            if (acc_err) begin
                state_nxt = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_nxt    = ST_WAIT;
                wait_cnt_nxt = WS_LOAD;
            end else begin
                state_nxt = ST_LAST;
            end
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            xfer_write <= 1'b0;
            xfer_idx   <= '0;
            xfer_mask  <= 4'd0;
            rd_word    <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept && !acc_err) begin
                xfer_write <= Hwrite;
                xfer_idx   <= acc_idx;
                xfer_mask  <= acc_mask;
                rd_word    <= fwd_word;
            end
        end
    end

    always_ff @(posedge Hclk) begin
        if (!Hreset && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (xfer_mask[i]) mem[xfer_idx][8*i +: 8] <= Hwdata[8*i +: 8];
            end
        end
    end

    assign Hreadyout = !((state == ST_WAIT) || (state == ST_ERR1));
    assign Hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;
    assign Hrdata    = (((state == ST_WAIT) || (state == ST_LAST)) && !xfer_write) ? rd_word : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with WAIT_STATES=1 and one with WAIT_STATES=0,
// driven by a simple AHB master with a scoreboard of expected data-phase responses.
module tb_ahb_sram_slave;

    typedef struct {
        bit          dut;
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          waits;
    } xfer_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic        Hclk, Hreset, Hsel0, Hsel1, Hwrite, Hready;
    logic [31:0] Haddr, Hwdata;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize;
    logic [31:0] rd0, rd1;
    logic [1:0]  rs0, rs1;
    logic        ro0, ro1;

    bit          dsel;
    logic        cur_rdy;
    logic [1:0]  cur_resp;
    logic [31:0] cur_rdata;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];
    xfer_t vec [0:18];

    assign cur_rdy   = dsel ? ro1 : ro0;
    assign cur_resp  = dsel ? rs1 : rs0;
    assign cur_rdata = dsel ? rd1 : rd0;

    ahb_sram_slave #(.WAIT_STATES(1)) u_dut1 (
        .Hclk(Hclk), .Hreset(Hreset), .Hsel(Hsel1), .Haddr(Haddr), .Htrans(Htrans),
        .Hwrite(Hwrite), .Hsize(Hsize), .Hwdata(Hwdata), .Hready(Hready),
        .Hrdata(rd1), .Hresp(rs1), .Hreadyout(ro1)
    );

    ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
        .Hclk(Hclk), .Hreset(Hreset), .Hsel(Hsel0), .Haddr(Haddr), .Htrans(Htrans),
        .Hwrite(Hwrite), .Hsize(Hsize), .Hwdata(Hwdata), .Hready(Hready),
        .Hrdata(rd0), .Hresp(rs0), .Hreadyout(ro0)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One non-pipelined transfer: address phase, then data phase until Hreadyout.
    task automatic xfer(input string name, input xfer_t t);
        exp_t e;
        int   waits;
        bit   done;
        @(posedge Hclk); #1;
        dsel   = t.dut;
        Hsel0  = (t.dut == 1'b0);
        Hsel1  = (t.dut == 1'b1);
        Htrans = 2'b10;
        Haddr  = t.addr;
        Hwrite = t.write;
        Hsize  = t.size;
        Hready = 1'b1;
        sb.push_back('{t.resp, t.rdata, t.waits});
        @(posedge Hclk); #1;
        Htrans = 2'b00;
        Hsel0  = 1'b0;
        Hsel1  = 1'b0;
        Hwdata = t.wdata;
        waits  = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge Hclk);
            if (cur_rdy === 1'b1) begin
                e = sb.pop_front();
                chk({name, "_resp"}, 32'(cur_resp), 32'(e.resp));
                chk({name, "_rdata"}, cur_rdata, e.rdata);
                chk({name, "_waits"}, 32'(waits), 32'(e.waits));
                done = 1'b1;
            end else begin
                chk({name, "_resp_stall"}, 32'(cur_resp), 32'(sb[0].resp));
                chk({name, "_rdata_stall"}, cur_rdata, sb[0].rdata);
                waits++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no Hreadyout within 40 cycles expected completion", name);
            void'(sb.pop_front());
        end
    endtask

    task automatic pipe_check(input string name);
        exp_t e;
        chk({name, "_rdy"}, 32'(cur_rdy), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb: got empty queue expected an entry", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_resp"}, 32'(cur_resp), 32'(e.resp));
            chk({name, "_rdata"}, cur_rdata, e.rdata);
        end
    endtask

    initial begin
        //          dut  wr   addr          size    wdata          resp   rdata          waits
        vec[0]  = '{1'b1, 1'b1, 32'h10,  3'b010, 32'hA5A5_1234, 2'b00, 32'h0,         1};
        vec[1]  = '{1'b1, 1'b0, 32'h10,  3'b010, 32'h0,         2'b00, 32'hA5A5_1234, 1};
        vec[2]  = '{1'b1, 1'b1, 32'h10,  3'b010, 32'h0000_0000, 2'b00, 32'h0,         1};
        vec[3]  = '{1'b1, 1'b1, 32'h11,  3'b000, 32'h0000_EF00, 2'b00, 32'h0,         1};
        vec[4]  = '{1'b1, 1'b0, 32'h10,  3'b010, 32'h0,         2'b00, 32'h0000_EF00, 1};
        vec[5]  = '{1'b1, 1'b1, 32'h12,  3'b001, 32'hBEEF_0000, 2'b00, 32'h0,         1};
        vec[6]  = '{1'b1, 1'b0, 32'h10,  3'b010, 32'h0,         2'b00, 32'hBEEF_EF00, 1};
        vec[7]  = '{1'b1, 1'b1, 32'h00,  3'b010, 32'h1234_5678, 2'b00, 32'h0,         1};
        vec[8]  = '{1'b1, 1'b1, 32'h02,  3'b010, 32'hFFFF_FFFF, 2'b01, 32'h0,         1};
        vec[9]  = '{1'b1, 1'b1, 32'h01,  3'b001, 32'hFFFF_FFFF, 2'b01, 32'h0,         1};
        vec[10] = '{1'b1, 1'b1, 32'h400, 3'b010, 32'hFFFF_FFFF, 2'b01, 32'h0,         1};
        vec[11] = '{1'b1, 1'b1, 32'h10,  3'b011, 32'hFFFF_FFFF, 2'b01, 32'h0,         1};
        vec[12] = '{1'b1, 1'b0, 32'h02,  3'b010, 32'h0,         2'b01, 32'h0,         1};
        vec[13] = '{1'b1, 1'b0, 32'h00,  3'b010, 32'h0,         2'b00, 32'h1234_5678, 1};
        vec[14] = '{1'b1, 1'b0, 32'h10,  3'b010, 32'h0,         2'b00, 32'hBEEF_EF00, 1};
        vec[15] = '{1'b1, 1'b1, 32'h30,  3'b010, 32'h0000_0000, 2'b00, 32'h0,         1};
        vec[16] = '{1'b1, 1'b0, 32'h13,  3'b000, 32'h0,         2'b00, 32'hBEEF_EF00, 1};
        vec[17] = '{1'b0, 1'b1, 32'h20,  3'b010, 32'hFFFF_FFFF, 2'b00, 32'h0,         0};
        vec[18] = '{1'b0, 1'b0, 32'h20,  3'b010, 32'h0,         2'b00, 32'hFFFF_FFFF, 0};

        Hreset = 1'b1;
        Hsel0  = 1'b0;
        Hsel1  = 1'b0;
        Haddr  = 32'h0;
        Htrans = 2'b00;
        Hwrite = 1'b0;
        Hsize  = 3'b010;
        Hwdata = 32'h0;
        Hready = 1'b1;
        dsel   = 1'b1;

        repeat (2) @(posedge Hclk);
        @(negedge Hclk);
        chk("rst_rdy1", 32'(ro1), 32'd1);
        chk("rst_resp1", 32'(rs1), 32'd0);
        chk("rst_rdata1", rd1, 32'd0);
        chk("rst_rdy0", 32'(ro0), 32'd1);
        chk("rst_resp0", 32'(rs0), 32'd0);
        chk("rst_rdata0", rd0, 32'd0);
        @(posedge Hclk); #1;
        Hreset = 1'b0;

        for (int i = 0; i < 19; i++) xfer($sformatf("vec%0d", i), vec[i]);

        // Zero-wait back-to-back write then read of the same word.
        @(posedge Hclk); #1;
        dsel   = 1'b0;
        Hsel0  = 1'b1;
        Htrans = 2'b10;
        Haddr  = 32'h20;
        Hwrite = 1'b1;
        Hsize  = 3'b010;
        Hready = 1'b1;
        sb.push_back('{2'b00, 32'h0, 0});
        @(posedge Hclk); #1;
        Hwrite = 1'b0;
        Hwdata = 32'h1111_2222;
        sb.push_back('{2'b00, 32'h1111_2222, 0});
        @(negedge Hclk);
        pipe_check("b2b_wr");
        @(posedge Hclk); #1;
        Htrans = 2'b00;
        Hsel0  = 1'b0;
        Hwdata = 32'h0;
        @(negedge Hclk);
        pipe_check("b2b_rd");
        xfer("b2b_readback", '{1'b0, 1'b0, 32'h20, 3'b010, 32'h0, 2'b00, 32'h1111_2222, 0});

        // IDLE, BUSY and NONSEQ-with-Hready-low must not start a transfer.
        dsel = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge Hclk); #1;
            Hsel1  = 1'b1;
            Haddr  = 32'h10;
            Hwrite = 1'b1;
            Hsize  = 3'b010;
            Hwdata = 32'h0;
            Htrans = (k == 0) ? 2'b00 : ((k == 1) ? 2'b01 : 2'b10);
            Hready = (k != 2);
            @(posedge Hclk); #1;
            Htrans = 2'b00;
            Hsel1  = 1'b0;
            Hready = 1'b1;
            @(negedge Hclk);
            chk($sformatf("noacc%0d_rdy", k), 32'(ro1), 32'd1);
            chk($sformatf("noacc%0d_resp", k), 32'(rs1), 32'd0);
        end
        xfer("noacc_readback", '{1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 2'b00, 32'hBEEF_EF00, 1});

        // Reset during the WAIT cycle of a write aborts it.
        @(posedge Hclk); #1;
        Hsel1  = 1'b1;
        Htrans = 2'b10;
        Haddr  = 32'h30;
        Hwrite = 1'b1;
        Hsize  = 3'b010;
        @(posedge Hclk); #1;
        Htrans = 2'b00;
        Hsel1  = 1'b0;
        Hwdata = 32'hDEAD_0001;
        @(negedge Hclk);
        chk("rstw_wait_rdy", 32'(ro1), 32'd0);
        Hreset = 1'b1;
        @(posedge Hclk); #1;
        Hreset = 1'b0;
        @(negedge Hclk);
        chk("rstw_rdy", 32'(ro1), 32'd1);
        chk("rstw_resp", 32'(rs1), 32'd0);
        chk("rstw_rdata", rd1, 32'd0);
        xfer("rstw_readback", '{1'b1, 1'b0, 32'h30, 3'b010, 32'h0, 2'b00, 32'h0, 1});

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite memory slave that sits upstream of the bus's slave-to-master response multiplexer: it decodes its own address/data phases and drives one slave's `Hrdata_S`/`Hresp_S`/`Hreadyout_S` lane. It provides `MEM_DEPTH` words of on-chip storage with programmable wait states, byte/halfword/word access and a two-cycle ERROR response. It is the standard memory target used by the bus testbenches.

## Interface
- `DATA_WIDTH`, 32 — data bus width; only 32 is supported.
- `ADDR_WIDTH`, 32 — address bus width.
- `MEM_DEPTH`, 256 — number of 32-bit words; word index = `Haddr[ADDR_WIDTH-1:2]`.
- `WAIT_STATES`, 1 — `Hreadyout` low cycles inserted per OKAY transfer (0..15).
- `Hclk` in 1 — bus clock; all logic on rising edge.
- `Hreset` in 1 — synchronous, active-high reset.
- `Hsel` in 1 — slave select from decoder.
- `Haddr` in ADDR_WIDTH — transfer address.
- `Htrans` in 2 — IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- `Hwrite` in 1 — 1 write, 0 read.
- `Hsize` in 3 — 000 byte, 001 halfword, 010 word.
- `Hwdata` in DATA_WIDTH — write data, data phase.
- `Hready` in 1 — global ready from response mux.
- `Hrdata` out DATA_WIDTH — read data.
- `Hresp` out 2 — 00 OKAY, 01 ERROR.
- `Hreadyout` out 1 — this slave's ready.

## Operation
- Address phase accepted on an edge where `Hsel && Hready && Htrans[1]`. IDLE/BUSY, or `Hsel=0`, accepts nothing and produces a zero-wait OKAY.
- Error check at acceptance:
  - `Hsize > 010`;
  - halfword with `Haddr[0]=1`;
  - word with `Haddr[1:0]!=0`;
  - word index `>= MEM_DEPTH`.
- FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
  - IDLE: `Hreadyout=1`, `Hresp=00`.
  - Valid accept → WAIT (counter loaded with `WAIT_STATES-1`) if `WAIT_STATES>0`, else → LAST.
  - WAIT: `Hreadyout=0`, `Hresp=00`; counter decrements; when 0 → LAST.
  - LAST: `Hreadyout=1`, `Hresp=00`; the transfer completes.
  - Error accept → ERR1: `Hreadyout=0`, `Hresp=01`; then → ERR2: `Hreadyout=1`, `Hresp=01`.
  - From LAST or ERR2: a new accept on the same edge starts the next transfer per the rules above (back-to-back pipelining); otherwise → IDLE.
- Byte lanes are little-endian:
  - byte uses lane `Haddr[1:0]`;
  - halfword uses lanes `{Haddr[1],0}` and `+1`;
  - word uses all four lanes.
- Write: address, size and lane mask are registered at acceptance. `Hwdata` lanes are committed to memory on the edge that ends LAST. Errored writes never modify memory.
- Read: the full word is registered at acceptance. `Hrdata` shows the whole word (all lanes) during WAIT/LAST of a read; it is 0 in every other state, including ERR1/ERR2.
- Read-after-write forwarding: if a read is accepted on the same edge that commits a write to the same word index, the captured read word merges the new write lanes.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, `Hreadyout=1`, `Hresp=00`, `Hrdata=0`, counter 0. Reset during WAIT/LAST aborts the pending write uncommitted.
- OKAY latency: data phase lasts `WAIT_STATES+1` cycles after acceptance; `Hrdata` is valid in the LAST cycle.
- ERROR: always exactly 2 cycles, independent of `WAIT_STATES`.
- `Hready` low (another slave stalling) blocks acceptance only; it does not affect an in-progress response.
- While in WAIT/ERR1 (`Hreadyout=0`), address-phase inputs are ignored; the master holds them.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to `Hreadyout`/`Hresp`.

## Test plan
- Reset, `WAIT_STATES=1`: write word `0xA5A5_1234` to `0x10`, then read `0x10` → `Hreadyout` is 0 for one cycle then 1 each transfer; read returns `0xA5A5_1234`, `Hresp=00`.
- Byte write `0xEF` at `0x11` over word `0x0000_0000` at `0x10`, then word read → `0x0000_EF00`; halfword write `0xBEEF` at `0x12` → `0xBEEF_EF00`.
- Word access at `0x02`, halfword at `0x01`, word at index 256 (`0x400`), and `Hsize=011` → each gives `Hresp=01` with `Hreadyout` 0 then 1; memory at the target is unchanged.
- `WAIT_STATES=0`, back-to-back NONSEQ write `0x20`=`0x1111_2222` then read `0x20` → zero-wait cycles; read returns `0x1111_2222` via forwarding.
- IDLE and BUSY with `Hsel=1`, and NONSEQ with `Hready=0` → no acceptance, `Hreadyout=1`, `Hresp=00`, memory unchanged.
- Assert `Hreset` during the WAIT cycle of a write `0x30`=`0xDEAD_0001` (location pre-written with `0x0`) → next cycle `Hreadyout=1`, `Hresp=00`; a later read of `0x30` returns `0x0`.
